// File: rtl/memory_ctrl.sv
// Single-port synchronous memory with valid/ready requests, byte strobes and a
// RD_LATENCY-deep read pipeline. Define MEM_PARITY_EN for per-byte even parity.
module memory_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [7:0]  INIT_BYTE  = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
`ifdef MEM_PARITY_EN
  input  logic                    perr_inject,
  output logic                    perr,
`endif
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rerr,
  output logic                    init_done
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam logic StInit = 1'b0;
  localparam logic StRun  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept, in_range, wr_en, rd_en;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == StInit) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == LastAddr) begin
        state_d    = StRun;
        init_ptr_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StInit;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  assign req_ready = (state_q == StRun);
  assign init_done = (state_q == StRun);
  assign accept    = req_valid & req_ready;
  assign in_range  = 32'(req_addr) < DEPTH;
  assign wr_en     = accept & req_we & in_range;
  assign rd_en     = accept & ~req_we;
  assign rd_word   = in_range ? mem_q[req_addr] : '0;

  // Array has no reset; the sweep defines its contents before RUN.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem_q[init_ptr_q] <= {NUM_BYTES{INIT_BYTE}};
    end else if (wr_en) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (req_wstrb[b]) mem_q[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic [NUM_BYTES-1:0] par_q [DEPTH];
  logic [NUM_BYTES-1:0] wr_par, rd_par;
  logic                 rd_perr;

  always_comb begin
    wr_par = '0;
    rd_par = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      wr_par[b] = ^req_wdata[8*b +: 8];
      rd_par[b] = ^rd_word[8*b +: 8];
    end
    wr_par[0] = wr_par[0] ^ perr_inject;
    rd_perr   = in_range && ((par_q[req_addr] ^ rd_par) != '0);
  end

  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      par_q[init_ptr_q] <= {NUM_BYTES{^INIT_BYTE}};
    end else if (wr_en) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (req_wstrb[b]) par_q[req_addr][b] <= wr_par[b];
      end
    end
  end
`endif

  // Each stage only loads on a valid input, so the last stage holds rdata between pulses.
  logic [RD_LATENCY-1:0] pipe_valid_q;
  logic [RD_LATENCY-1:0] pipe_err_q;
  logic [DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];
`ifdef MEM_PARITY_EN
  logic [RD_LATENCY-1:0] pipe_perr_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid_q <= '0;
      pipe_err_q   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_data_q[i] <= '0;
`ifdef MEM_PARITY_EN
      pipe_perr_q  <= '0;
`endif
    end else begin
      pipe_valid_q[0] <= rd_en;
      if (rd_en) begin
        pipe_data_q[0] <= rd_word;
        pipe_err_q[0]  <= ~in_range;
`ifdef MEM_PARITY_EN
        pipe_perr_q[0] <= rd_perr;
`endif
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        if (pipe_valid_q[i-1]) begin
          pipe_data_q[i] <= pipe_data_q[i-1];
          pipe_err_q[i]  <= pipe_err_q[i-1];
`ifdef MEM_PARITY_EN
          pipe_perr_q[i] <= pipe_perr_q[i-1];
`endif
        end
      end
    end
  end

  assign rvalid = pipe_valid_q[RD_LATENCY-1];
  assign rdata  = pipe_data_q[RD_LATENCY-1];
  assign rerr   = pipe_err_q[RD_LATENCY-1];
`ifdef MEM_PARITY_EN
  assign perr   = pipe_perr_q[RD_LATENCY-1];
`endif

endmodule

// File: tb/tb_memory_ctrl.sv
// Randomised bench for memory_ctrl (DEPTH=12, RD_LATENCY=3) against a behavioural
// model: word array, per-address parity-fault flags and a queue of due responses.
module tb_memory_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 12;
  localparam int unsigned LAT   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_wstrb;
  logic          rvalid, rerr, init_done;
  logic [DW-1:0] rdata;
  logic          inj_v;
`ifdef MEM_PARITY_EN
  logic          perr;
`endif

  always #5 clk = ~clk;

  memory_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .RD_LATENCY (LAT),
    .INIT_BYTE  (8'hFF)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
`ifdef MEM_PARITY_EN
    .perr_inject (inj_v),
    .perr        (perr),
`endif
    .rvalid      (rvalid),
    .rdata       (rdata),
    .rerr        (rerr),
    .init_done   (init_done)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
    logic        p;
  } rsp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rel      = 0;
  logic [31:0] m_mem [DEPTH];
  logic [3:0]  m_bad [DEPTH];
  rsp_t        q [$];
  logic [31:0] last_d;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, update the model at the edge, check at the next negedge.
  task automatic cycle(input logic v, input logic we, input logic [3:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    logic acc, inr, exp_v;
    rsp_t r;
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws;
    acc = v && (rel >= int'(DEPTH));
    inr = (32'(a) < DEPTH);
    @(posedge clk);
    cyc++;
    rel++;
    if (acc && we && inr) begin
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) begin
          m_mem[a][8*b +: 8] = wd[8*b +: 8];
          m_bad[a][b] = (b == 0) && inj_v;
        end
      end
    end
    if (acc && !we) begin
      r.due = cyc + int'(LAT) - 1;
      r.d   = inr ? m_mem[a] : 32'h0;
      r.e   = !inr;
      r.p   = inr && (m_bad[a] != 4'h0);
      q.push_back(r);
    end
    @(negedge clk);
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    check_eq("req_ready", req_ready, rel >= int'(DEPTH));
    check_eq("init_done", init_done, rel >= int'(DEPTH));
    check_eq("rvalid", rvalid, exp_v);
    if (exp_v) begin
      last_d = q[0].d;
      check_eq("rerr", rerr, q[0].e);
`ifdef MEM_PARITY_EN
      check_eq("perr", perr, q[0].p);
`endif
      void'(q.pop_front());
    end
    check_eq("rdata", rdata, last_d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  // Assert reset at a negedge, check the asynchronous clear, hold, release.
  task automatic do_reset();
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    check_eq("rst_rvalid", rvalid, 1'b0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_ready", req_ready, 1'b0);
    check_eq("rst_init_done", init_done, 1'b0);
    q.delete();
    last_d = 32'h0;
    rel    = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_mem[i] = 32'hFFFF_FFFF;
      m_bad[i] = 4'h0;
    end
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_hold_rvalid", rvalid, 1'b0);
    end
    reset = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 60) begin
      idle(1);
      n++;
    end
    check_eq("sweep_len", 64'(n), 64'(DEPTH));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; inj_v = 1'b0; last_d = '0;
    @(negedge clk);
    do_reset();
    wait_ready();

    // Every address, including the out-of-range tail, back to back.
    for (int a = 0; a < 16; a++) cycle(1'b1, 1'b0, 4'(a), 32'h0, 4'h0);
    idle(LAT + 1);
    check_eq("init_last", rdata, 32'h0);

    cycle(1'b1, 1'b1, 4'd13, 32'h0000_DEAD, 4'hF);
    cycle(1'b1, 1'b0, 4'd13, 32'h0, 4'h0);
    idle(LAT + 1);
    check_eq("oor_rd", rdata, 32'h0);
    cycle(1'b1, 1'b0, 4'd11, 32'h0, 4'h0);
    idle(LAT + 1);
    check_eq("rd_11", rdata, 32'hFFFF_FFFF);

    cycle(1'b1, 1'b1, 4'd3, 32'h1122_3344, 4'b0101);
    cycle(1'b1, 1'b1, 4'd4, 32'h5555_5555, 4'b0000);
    cycle(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    cycle(1'b1, 1'b0, 4'd4, 32'h0, 4'h0);
    idle(LAT + 1);
    check_eq("wstrb0_noop", rdata, 32'hFFFF_FFFF);

    // Write then immediately read the same address, then a streamed readback.
    for (int a = 0; a < 3; a++) cycle(1'b1, 1'b1, 4'(a), 32'hA0 + 32'(a), 4'hF);
    cycle(1'b1, 1'b1, 4'd7, 32'hCAFE_F00D, 4'hF);
    cycle(1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
    for (int a = 0; a < 3; a++) cycle(1'b1, 1'b0, 4'(a), 32'h0, 4'h0);
    idle(LAT + 1);
    check_eq("stream_last", rdata, 32'hA2);
    cycle(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    idle(LAT + 1);
    check_eq("strb_rd", rdata, 32'hFF22_FF44);

`ifdef MEM_PARITY_EN
    inj_v = 1'b1;
    cycle(1'b1, 1'b1, 4'd5, 32'h0101_0101, 4'hF);
    inj_v = 1'b0;
    cycle(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    idle(LAT + 1);
    cycle(1'b1, 1'b1, 4'd5, 32'h0202_0202, 4'hF);
    cycle(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    idle(LAT + 1);
`endif

    for (int i = 0; i < 400; i++) begin
      inj_v = 1'b0;
`ifdef MEM_PARITY_EN
      inj_v = ($urandom_range(0, 7) == 0);
`endif
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
            $urandom, 4'($urandom_range(0, 15)));
    end
    inj_v = 1'b0;
    idle(LAT + 1);

    // Reset with a read in flight: its response must never appear.
    cycle(1'b1, 1'b1, 4'd0, 32'h1234_5678, 4'hF);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
    idle(1);
    do_reset();
    wait_ready();
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
    idle(LAT + 1);
    check_eq("rst_reread", rdata, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
